uart_rx_ctrl: RTL and testbench

- Receive-side controller of the UART-to-APB bridge.
- Runs the RX frame state machine and the oversampling edge/bit counters.
- Sequences the enables for the data sampler, start checker, deserializer, parity checker and stop checker.
- Consumes the checkers' registered error flags and issues a one-cycle data_valid for a good frame toward the APB-side logic.

---
 rtl/uart_rx_pkg.sv | 12 +
 rtl/uart_edge_bit_cnt.sv | 48 ++++
 rtl/uart_rx_ctrl.sv | 130 +++++++++++++
 tb/tb_uart_rx_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the UART receive controller.
package uart_rx_pkg;
  localparam int DATA_W_DEF     = 8;
  localparam int PRESCALE_W_DEF = 6;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;

  // Bit counter spans start, data, parity and stop bits.
  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 3);
  endfunction
endpackage

// File: rtl/uart_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter with enable, sync clear and wrap flag.
module uart_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int BIT_W      = bit_cnt_w(DATA_W_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic [PRESCALE_W-1:0] edge_cnt_o,
  output logic [BIT_W-1:0]      bit_cnt_o,
  output logic                  wrap_o
);
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_W-1:0]      bit_q, bit_d;

  assign wrap_o = en_i && (edge_q == prescale_i - PRESCALE_W'(1));

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (clr_i) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (wrap_o) begin
      edge_d = '0;
      bit_d  = bit_q + BIT_W'(1);
    end else if (en_i) begin
      edge_d = edge_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt_o = edge_q;
  assign bit_cnt_o  = bit_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART RX frame controller: FSM, check/deserializer pulse sequencing, data_valid.
// Optional UART_RX_ERR_CNT_EN adds a saturating frame_err_cnt output.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_in,
  input  logic [PRESCALE_W-1:0]        prescale,
  input  logic                         par_en,
  input  logic                         strt_glitch,
  input  logic                         par_err,
  input  logic                         stop_err,
  output logic [PRESCALE_W-1:0]        edge_cnt,
  output logic [bit_cnt_w(DATA_W)-1:0] bit_cnt,
  output logic                         dat_samp_en,
  output logic                         strt_chk_en,
  output logic                         deser_en,
  output logic                         par_chk_en,
  output logic                         stop_chk_en,
  output logic                         data_valid
`ifdef UART_RX_ERR_CNT_EN
  ,output logic [7:0]                  frame_err_cnt
`endif
);
  localparam int BIT_W = bit_cnt_w(DATA_W);

  rx_state_e state_q, state_d;
  logic      cnt_en, cnt_clr, wrap, pre_pulse, stop_eval, frame_ok;
  logic      par_err_q;
  logic      dat_samp_en_q, strt_chk_en_q, deser_en_q, par_chk_en_q, stop_chk_en_q, data_valid_q;

  uart_edge_bit_cnt #(.PRESCALE_W(PRESCALE_W), .BIT_W(BIT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .en_i       (cnt_en),
    .clr_i      (cnt_clr),
    .prescale_i (prescale),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt),
    .wrap_o     (wrap)
  );

  assign cnt_en    = (state_q != IDLE);
  // Pulses are registered, so decode one edge early to land on edge prescale-2.
  assign pre_pulse = (edge_cnt == prescale - PRESCALE_W'(3));
  assign stop_eval = (state_q == STOP) && wrap;
  assign frame_ok  = stop_eval && !stop_err && !par_err_q;

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_in) state_d = START;
      end
      START: begin
        if (wrap) begin
          if (strt_glitch) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (wrap && (bit_cnt == BIT_W'(DATA_W))) state_d = par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (wrap) state_d = STOP;
      end
      STOP: begin
        if (wrap) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      par_err_q     <= 1'b0;
      dat_samp_en_q <= 1'b0;
      strt_chk_en_q <= 1'b0;
      deser_en_q    <= 1'b0;
      par_chk_en_q  <= 1'b0;
      stop_chk_en_q <= 1'b0;
      data_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      dat_samp_en_q <= (state_d != IDLE);
      strt_chk_en_q <= (state_q == START)  && pre_pulse;
      deser_en_q    <= (state_q == DATA)   && pre_pulse;
      par_chk_en_q  <= (state_q == PARITY) && pre_pulse;
      stop_chk_en_q <= (state_q == STOP)   && pre_pulse;
      data_valid_q  <= frame_ok;
      if (state_d == IDLE)                  par_err_q <= 1'b0;
      else if ((state_q == PARITY) && wrap) par_err_q <= par_err;
    end
  end

  assign dat_samp_en = dat_samp_en_q;
  assign strt_chk_en = strt_chk_en_q;
  assign deser_en    = deser_en_q;
  assign par_chk_en  = par_chk_en_q;
  assign stop_chk_en = stop_chk_en_q;
  assign data_valid  = data_valid_q;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                                     err_cnt_q <= 8'd0;
    else if (stop_eval && (stop_err || par_err_q) && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign frame_err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frame driver, sampler/checker models and frame-level expectations.
module tb_uart_rx_ctrl;
  logic       clk = 1'b0, rst = 1'b0, rx_in = 1'b1, par_en = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       strt_glitch, par_err, stop_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, strt_chk_en, deser_en, par_chk_en, stop_chk_en, data_valid;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] frame_err_cnt;
`endif

  int n_checks = 0, n_fail = 0, cyc = 0, exp_err = 0;
  int n_deser = 0, n_strt = 0, stop_e = -1, stop_b = -1;
  int dv_cyc[$];
  logic [7:0] dv_dat[$];
  logic       samp_bit;
  logic [7:0] data_m;

  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale), .par_en(par_en),
    .strt_glitch(strt_glitch), .par_err(par_err), .stop_err(stop_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .strt_chk_en(strt_chk_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
    .stop_chk_en(stop_chk_en), .data_valid(data_valid)
`ifdef UART_RX_ERR_CNT_EN
    ,.frame_err_cnt(frame_err_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Sampler (mid-bit), deserializer and checker models with registered one-cycle results.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_bit <= 1'b1; data_m <= 8'h00;
      strt_glitch <= 1'b0; par_err <= 1'b0; stop_err <= 1'b0;
    end else begin
      if (dat_samp_en && (edge_cnt == (prescale >> 1))) samp_bit <= rx_in;
      strt_glitch <= strt_chk_en & samp_bit;
      par_err     <= par_chk_en & (samp_bit ^ (^data_m));
      stop_err    <= stop_chk_en & ~samp_bit;
      if (deser_en) data_m <= {samp_bit, data_m[7:1]};
    end
  end

  always @(negedge clk) begin
    if (deser_en)    n_deser++;
    if (strt_chk_en) n_strt++;
    if (stop_chk_en) begin stop_e = int'(edge_cnt); stop_b = int'(bit_cnt); end
    if (data_valid)  begin dv_cyc.push_back(cyc); dv_dat.push_back(data_m); end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one frame LSB first with even parity; max_cyc >= 0 stops early.
  task automatic drive_frame(input logic [7:0] d, input logic pe, input logic bad_par,
                             input logic bad_stop, input int max_cyc);
    logic [10:0] bits;
    int nb, n;
    nb = pe ? 11 : 10;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pe) begin bits[9] = (^d) ^ bad_par; bits[10] = ~bad_stop; end
    else    bits[9] = ~bad_stop;
    n = 0;
    for (int b = 0; b < nb; b++)
      for (int e = 0; e < int'(prescale); e++) begin
        if (max_cyc >= 0 && n == max_cyc) return;
        rx_in = bits[b];
        tick();
        n++;
      end
    rx_in = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_in = 1'b0;
    repeat (3) tick();
    n_checks++; if (edge_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_edge got %0d want 0", edge_cnt); end
    n_checks++; if (bit_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_bit got %0d want 0", bit_cnt); end
    n_checks++;
    if ({dat_samp_en, strt_chk_en, deser_en, par_chk_en, stop_chk_en, data_valid} !== 6'b0) begin
      n_fail++; $display("FAIL reset_enables got %b want 000000",
        {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stop_chk_en, data_valid});
    end
`ifdef UART_RX_ERR_CNT_EN
    n_checks++; if (frame_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt got %0d want 0", frame_err_cnt); end
`endif
    rx_in = 1'b1; rst = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    int d0, q0, t0;
    prescale = 6'd8; par_en = 1'b0;
    d0 = n_deser; q0 = dv_cyc.size(); t0 = cyc;
    drive_frame(8'hA5, 1'b0, 1'b0, 1'b0, -1);
    repeat (5) tick();
    n_checks++; if (n_deser - d0 != 8) begin n_fail++; $display("FAIL basic_deser_cnt got %0d want 8", n_deser - d0); end
    n_checks++; if (stop_e != 6 || stop_b != 9) begin n_fail++; $display("FAIL basic_stop_pos got e%0d b%0d want e6 b9", stop_e, stop_b); end
    n_checks++; if (dv_cyc.size() - q0 != 1) begin n_fail++; $display("FAIL basic_dv_cnt got %0d want 1", dv_cyc.size() - q0); end
    if (dv_cyc.size() > q0) begin
      n_checks++; if (dv_cyc[q0] != t0 + 81) begin n_fail++; $display("FAIL basic_dv_time got %0d want %0d", dv_cyc[q0] - t0, 81); end
      n_checks++; if (dv_dat[q0] !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h want a5", dv_dat[q0]); end
    end
    n_checks++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin n_fail++; $display("FAIL basic_idle_cnt got e%0d b%0d want 0 0", edge_cnt, bit_cnt); end
  endtask

  task automatic test_parity_err();
    int q0;
    prescale = 6'd16; par_en = 1'b1;
    q0 = dv_cyc.size();
    drive_frame(8'h6B, 1'b1, 1'b1, 1'b0, -1);
    if (exp_err < 255) exp_err++;
    repeat (5) tick();
    n_checks++; if (dv_cyc.size() != q0) begin n_fail++; $display("FAIL parerr_dv got %0d want 0", dv_cyc.size() - q0); end
    n_checks++; if (dat_samp_en !== 1'b0) begin n_fail++; $display("FAIL parerr_idle got %b want 0", dat_samp_en); end
`ifdef UART_RX_ERR_CNT_EN
    n_checks++; if (int'(frame_err_cnt) != exp_err) begin n_fail++; $display("FAIL parerr_errcnt got %0d want %0d", frame_err_cnt, exp_err); end
`endif
  endtask

  task automatic test_stop_err();
    int q0;
    prescale = 6'd8; par_en = 1'b0;
    q0 = dv_cyc.size();
    drive_frame(8'h3E, 1'b0, 1'b0, 1'b1, -1);
    if (exp_err < 255) exp_err++;
    repeat (4) tick();
    n_checks++; if (dv_cyc.size() != q0) begin n_fail++; $display("FAIL stoperr_dv got %0d want 0", dv_cyc.size() - q0); end
    n_checks++; if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0) begin n_fail++; $display("FAIL stoperr_idle_cnt got e%0d b%0d want 0 0", edge_cnt, bit_cnt); end
`ifdef UART_RX_ERR_CNT_EN
    n_checks++; if (int'(frame_err_cnt) != exp_err) begin n_fail++; $display("FAIL stoperr_errcnt got %0d want %0d", frame_err_cnt, exp_err); end
`endif
  endtask

  task automatic test_glitch();
    int d0, s0, q0;
    prescale = 6'd8; par_en = 1'b0;
    d0 = n_deser; s0 = n_strt; q0 = dv_cyc.size();
    rx_in = 1'b0;
    repeat (3) tick();
    rx_in = 1'b1;
    repeat (7) tick();
    n_checks++; if (dat_samp_en !== 1'b0 || bit_cnt !== 4'd0 || edge_cnt !== 6'd0) begin
      n_fail++; $display("FAIL glitch_idle got samp%b e%0d b%0d want 0 0 0", dat_samp_en, edge_cnt, bit_cnt); end
    repeat (10) tick();
    n_checks++; if (n_deser != d0) begin n_fail++; $display("FAIL glitch_deser got %0d want 0", n_deser - d0); end
    n_checks++; if (n_strt - s0 != 1) begin n_fail++; $display("FAIL glitch_strt got %0d want 1", n_strt - s0); end
    n_checks++; if (dv_cyc.size() != q0) begin n_fail++; $display("FAIL glitch_dv got %0d want 0", dv_cyc.size() - q0); end
`ifdef UART_RX_ERR_CNT_EN
    n_checks++; if (int'(frame_err_cnt) != exp_err) begin n_fail++; $display("FAIL glitch_errcnt got %0d want %0d", frame_err_cnt, exp_err); end
`endif
  endtask

  task automatic test_random();
    int q0, t0, ps, nb;
    logic [7:0] d;
    logic pe, bp, bs, good;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2)) 0: ps = 8; 1: ps = 16; default: ps = 32; endcase
      prescale = ps[5:0];
      d  = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      bp = pe && ($urandom_range(0, 3) == 0);
      bs = ($urandom_range(0, 3) == 0);
      par_en = pe;
      good = !bp && !bs;
      nb = pe ? 11 : 10;
      q0 = dv_cyc.size(); t0 = cyc;
      drive_frame(d, pe, bp, bs, -1);
      repeat (4) tick();
      if (!good && exp_err < 255) exp_err++;
      n_checks++; if (dv_cyc.size() - q0 != (good ? 1 : 0)) begin
        n_fail++; $display("FAIL rand%0d_dv_cnt got %0d want %0d", i, dv_cyc.size() - q0, good ? 1 : 0); end
      if (good && dv_cyc.size() > q0) begin
        n_checks++; if (dv_dat[q0] !== d) begin n_fail++; $display("FAIL rand%0d_data got %h want %h", i, dv_dat[q0], d); end
        n_checks++; if (dv_cyc[q0] != t0 + nb * ps + 1) begin
          n_fail++; $display("FAIL rand%0d_dv_time got %0d want %0d", i, dv_cyc[q0] - t0, nb * ps + 1); end
      end
`ifdef UART_RX_ERR_CNT_EN
      n_checks++; if (int'(frame_err_cnt) != exp_err) begin n_fail++; $display("FAIL rand%0d_errcnt got %0d want %0d", i, frame_err_cnt, exp_err); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int q0;
    prescale = 6'd8; par_en = 1'b0;
    q0 = dv_cyc.size();
    drive_frame(8'hC3, 1'b0, 1'b0, 1'b0, 36);
    n_checks++; if (dat_samp_en !== 1'b1 || bit_cnt !== 4'd4) begin
      n_fail++; $display("FAIL rstmid_inflight got samp%b b%0d want 1 4", dat_samp_en, bit_cnt); end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, deser_en, par_chk_en, stop_chk_en, data_valid} !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_async got e%0d b%0d en%b want all 0", edge_cnt, bit_cnt,
        {dat_samp_en, strt_chk_en, deser_en, par_chk_en, stop_chk_en, data_valid}); end
    rx_in = 1'b1;
    repeat (2) tick();
    rst = 1'b1; exp_err = 0;
    repeat (3) tick();
    n_checks++; if (dv_cyc.size() != q0) begin n_fail++; $display("FAIL rstmid_no_dv got %0d want 0", dv_cyc.size() - q0); end
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b0, -1);
    repeat (4) tick();
    n_checks++; if (dv_cyc.size() - q0 != 1) begin n_fail++; $display("FAIL rstmid_next_dv got %0d want 1", dv_cyc.size() - q0); end
    if (dv_cyc.size() > q0) begin
      n_checks++; if (dv_dat[q0] !== 8'h3C) begin n_fail++; $display("FAIL rstmid_next_data got %h want 3c", dv_dat[q0]); end
    end
`ifdef UART_RX_ERR_CNT_EN
    n_checks++; if (int'(frame_err_cnt) != exp_err) begin n_fail++; $display("FAIL rstmid_errcnt got %0d want %0d", frame_err_cnt, exp_err); end
`endif
  endtask

  task automatic test_back_to_back();
    int q0, t0;
    prescale = 6'd32; par_en = 1'b0;
    q0 = dv_cyc.size(); t0 = cyc;
    drive_frame(8'h11, 1'b0, 1'b0, 1'b0, -1);
    drive_frame(8'hEE, 1'b0, 1'b0, 1'b0, -1);
    repeat (6) tick();
    n_checks++; if (dv_cyc.size() - q0 != 2) begin n_fail++; $display("FAIL b2b_dv_cnt got %0d want 2", dv_cyc.size() - q0); end
    if (dv_cyc.size() >= q0 + 2) begin
      n_checks++; if (dv_cyc[q0] != t0 + 321) begin n_fail++; $display("FAIL b2b_first_time got %0d want 321", dv_cyc[q0] - t0); end
      n_checks++; if (dv_cyc[q0+1] - dv_cyc[q0] != 321) begin
        n_fail++; $display("FAIL b2b_spacing got %0d want 321", dv_cyc[q0+1] - dv_cyc[q0]); end
      n_checks++; if (dv_dat[q0] !== 8'h11 || dv_dat[q0+1] !== 8'hEE) begin
        n_fail++; $display("FAIL b2b_data got %h %h want 11 ee", dv_dat[q0], dv_dat[q0+1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
